// File: rtl/freq_meter_bcd_pkg.sv
// Shared types and constants for the freq_meter_bcd frequency meter.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      LATCH = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'h9;

endpackage

// File: rtl/freq_meter_bcd_if.sv
// Measurement bus of freq_meter_bcd: the meter takes the slave side, its user the master side.
// Handshake: VALID is a single-cycle strobe with no back-pressure; FREQ_BCD and OVF are meaningful while VALID is high and hold afterwards.
interface freq_meter_bcd_if #(
   parameter int DIGITS = 6
);
   logic                CE;
   logic                SIG_IN;
   logic [4*DIGITS-1:0] FREQ_BCD;
   logic                VALID;
   logic                OVF;

   modport master (
      output CE,
      output SIG_IN,
      input  FREQ_BCD,
      input  VALID,
      input  OVF
   );

   modport slave (
      input  CE,
      input  SIG_IN,
      output FREQ_BCD,
      output VALID,
      output OVF
   );
endinterface

// File: rtl/freq_meter_bcd_decade.sv
// One BCD decade of the edge counter: counts 0-9 on inc, carries out while at 9 and incremented.
module bcd_decade
   import freq_meter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   input  logic       load1,
   output bcd_digit_t digit,
   output logic       carry
);

   bcd_digit_t digit_q, digit_d;

   // clr wins over inc; load1 only matters together with clr
   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = load1 ? 4'h1 : 4'h0;
      end else if (inc) begin
         digit_d = (digit_q == BCD_MAX) ? 4'h0 : digit_q + 4'h1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = inc & (digit_q == BCD_MAX);

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts SIG_IN rises per GATE_CYCLES window into DIGITS BCD decades.
// Define FREQ_METER_SAT_EN to saturate at full scale on overflow; otherwise the count wraps.
module freq_meter_bcd
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int DIGITS      = 6
) (
   input  logic            CP_50M,
   input  logic            RST,
   freq_meter_bcd_if.slave bus,
   output state_t          fsm_state
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 2);

   state_t              state_q, state_d;
   logic [GW-1:0]       gate_q, gate_d;
   logic [2:0]          sync_q, sync_d;
   logic                ovf_q, ovf_d;
   logic [4*DIGITS-1:0] freq_q, freq_d;
   logic                res_ovf_q, res_ovf_d;

   logic                sig_rise;
   logic                in_count;
   logic                latch_en;
   logic                cnt_clr;
   logic                cnt_load1;
   logic                cnt_inc;
   logic                ovf_set;
   logic                inc_w   [DIGITS];
   logic                carry_w [DIGITS];
   logic [4*DIGITS-1:0] bcd_flat;

   // sync_q[0..1] is the synchronizer, sync_q[2] the delayed copy for rise detection
   assign sync_d   = {sync_q[1:0], bus.SIG_IN};
   assign sig_rise = sync_q[1] & ~sync_q[2];

   always_ff @(posedge CP_50M) begin
      if (RST) begin
         state_q   <= IDLE;
         gate_q    <= '0;
         sync_q    <= '0;
         ovf_q     <= 1'b0;
         freq_q    <= '0;
         res_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gate_q    <= gate_d;
         sync_q    <= sync_d;
         ovf_q     <= ovf_d;
         freq_q    <= freq_d;
         res_ovf_q <= res_ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.CE) state_d = COUNT;
         COUNT: begin
            if (!bus.CE) state_d = IDLE;
            else if (gate_q == GATE_LAST) state_d = LATCH;
         end
         LATCH:   state_d = bus.CE ? COUNT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_count  = (state_q == COUNT);
      latch_en  = (state_q == LATCH);
      cnt_clr   = !in_count;
      cnt_load1 = latch_en & sig_rise;
      gate_d    = in_count ? gate_q + GW'(1) : '0;
      freq_d    = latch_en ? bcd_flat : freq_q;
      res_ovf_d = latch_en ? ovf_q : res_ovf_q;
   end

`ifdef FREQ_METER_SAT_EN
   logic all_nines;

   always_comb begin
      all_nines = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_flat[4*i +: 4] != BCD_MAX) all_nines = 1'b0;
      end
   end

   // once at full scale the count freezes; the rise that would carry out flags overflow
   assign cnt_inc = in_count & sig_rise & ~all_nines;
   assign ovf_set = carry_w[DIGITS-1] | (in_count & sig_rise & all_nines);
`else
   assign cnt_inc = in_count & sig_rise;
   assign ovf_set = carry_w[DIGITS-1];
`endif

   assign ovf_d = in_count ? (ovf_q | ovf_set) : 1'b0;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dec
      if (i == 0) begin : g_lsd
         assign inc_w[i] = cnt_inc;
      end else begin : g_upper
         assign inc_w[i] = carry_w[i-1];
      end

      bcd_decade u_decade (
         .clk   (CP_50M),
         .rst   (RST),
         .inc   (inc_w[i]),
         .clr   (cnt_clr),
         .load1 (cnt_load1 & (i == 0)),
         .digit (bcd_flat[4*i +: 4]),
         .carry (carry_w[i])
      );
   end

   assign bus.VALID    = latch_en;
   assign bus.FREQ_BCD = latch_en ? bcd_flat : freq_q;
   assign bus.OVF      = latch_en ? ovf_q : res_ovf_q;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Bench for freq_meter_bcd: a 6-decade and a 2-decade meter share one stimulus and are
// compared with a model that logs sampled SIG_IN rises and counts them per gate window.
`timescale 1ns/1ps
module tb_freq_meter_bcd;
   import freq_meter_pkg::*;

   localparam int G = 1000;

   logic   clk = 1'b0;
   logic   rst;
   logic   ce;
   logic   sig;
   state_t st6;
   state_t st2;

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   always #10 clk = ~clk;

   freq_meter_bcd_if #(.DIGITS(6)) bus6 ();
   freq_meter_bcd_if #(.DIGITS(2)) bus2 ();

   assign bus6.CE     = ce;
   assign bus6.SIG_IN = sig;
   assign bus2.CE     = ce;
   assign bus2.SIG_IN = sig;

   freq_meter_bcd #(.GATE_CYCLES(G), .DIGITS(6)) u_dut6 (
      .CP_50M    (clk),
      .RST       (rst),
      .bus       (bus6),
      .fsm_state (st6)
   );

   freq_meter_bcd #(.GATE_CYCLES(G), .DIGITS(2)) u_dut2 (
      .CP_50M    (clk),
      .RST       (rst),
      .bus       (bus2),
      .fsm_state (st2)
   );

   // ---------------- reference model: log of sampled rises and window start ----------------
   int   cyc = 0;
   int   rise_q[$];
   logic prev_sig = 1'b0;
   logic idle_m = 1'b1;
   int   e0 = 0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         prev_sig = 1'b0;
         idle_m   = 1'b1;
      end else begin
         if (sig && !prev_sig) rise_q.push_back(cyc);
         prev_sig = sig;
         if (!ce) idle_m = 1'b1;
         else if (idle_m) begin
            idle_m = 1'b0;
            e0     = cyc;
         end
      end
      cyc++;
   end

   function automatic int count_rises(input int lo, input int hi);
      int n = 0;
      foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
      return n;
   endfunction

   function automatic int pow10(input int d);
      int p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   function automatic int meter_value(input int n, input int digits);
      int full = pow10(digits) - 1;
`ifdef FREQ_METER_SAT_EN
      return (n > full) ? full : n;
`else
      return n % (full + 1);
`endif
   endfunction

   function automatic logic [23:0] to_bcd(input int val, input int digits);
      logic [23:0] r = '0;
      int x = val;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // ---------------- SIG_IN driver: 0 manual, 1 period 10, 2 fast random, 3 slow random ----------------
   int mode = 0;
   int phase_len;

   initial forever begin
      if (mode == 0) begin
         @(negedge clk);
      end else begin
         sig = ~sig;
         case (mode)
            1:       phase_len = 5;
            2:       phase_len = $urandom_range(6, 2);
            default: phase_len = $urandom_range(40, 12);
         endcase
         repeat (phase_len) @(negedge clk);
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, output int v);
      int n = 0;
      v = -1;
      while (v < 0 && n < G + 20) begin
         @(negedge clk);
         if (bus6.VALID === 1'b1) v = cyc - 1;
         n++;
      end
      check_int({tag, "_seen"}, int'(v >= 0), 1);
   endtask

   task automatic check_window(input string tag, input int v, input int exp_v);
      int lo;
      int hi;
      int n;
      check_int({tag, "_latency"}, v, exp_v);
      lo = v - G - 1;
      if (lo < e0 - 1) lo = e0 - 1;
      hi = v - 2;
      n  = count_rises(lo, hi);
      check({tag, "_freq6"}, bus6.FREQ_BCD, to_bcd(meter_value(n, 6), 6));
      check({tag, "_ovf6"}, 24'(bus6.OVF), 24'(n > 999999));
      check({tag, "_freq2"}, 24'(bus2.FREQ_BCD), to_bcd(meter_value(n, 2), 2));
      check({tag, "_ovf2"}, 24'(bus2.OVF), 24'(n > 99));
      check({tag, "_valid2"}, 24'(bus2.VALID), 24'h1);
   endtask

   task automatic run_window(input string tag, input int exp_v, output int v);
      wait_valid(tag, v);
      if (v >= 0) check_window(tag, v, exp_v);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          v;
      int          exp_v;
      int          target;
      int          guard;
      int          quiet;
      logic [23:0] held6;

      rst  = 1'b1;
      ce   = 1'b0;
      sig  = 1'b0;
      mode = 0;
      repeat (4) @(negedge clk);
      check("rst_freq6", bus6.FREQ_BCD, 24'h0);
      check("rst_valid6", 24'(bus6.VALID), 24'h0);
      check("rst_ovf6", 24'(bus6.OVF), 24'h0);
      check("rst_freq2", 24'(bus2.FREQ_BCD), 24'h0);
      check_int("rst_state6", int'(st6), int'(IDLE));
      check_int("rst_state2", int'(st2), int'(IDLE));
      rst = 1'b0;

      // period-10 input, continuous measurement
      mode = 1;
      repeat (7) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      exp_v = e0 + G - 1;
      run_window("fix_w1", exp_v, v);
      exp_v = exp_v + G;
      run_window("fix_w2", exp_v, v);
      check("fix_w2_literal", bus6.FREQ_BCD, 24'h000100);
      check("fix_w2_ovf6", 24'(bus6.OVF), 24'h0);

      // fast random input overflows the 2-decade meter
      mode = 2;
      for (int w = 0; w < 2; w++) begin
         exp_v = exp_v + G;
         run_window("fast", exp_v, v);
      end

      // slow random input stays below 100 rises per window
      mode = 3;
      for (int w = 0; w < 2; w++) begin
         exp_v = exp_v + G;
         run_window("slow", exp_v, v);
      end

      // quiet the input mid-window, then place a rise whose detect lands in LATCH
      repeat (200) @(negedge clk);
      mode = 0;
      sig  = 1'b0;
      exp_v = exp_v + G;
      run_window("mix", exp_v, v);
      for (int p = 0; p < 3; p++) begin
         sig = 1'b1;
         repeat (3) @(negedge clk);
         sig = 1'b0;
         repeat (3) @(negedge clk);
      end
      target = exp_v + G - 1;
      guard  = 0;
      while (cyc != target && guard < 2 * G) begin
         @(negedge clk);
         guard++;
      end
      sig = 1'b1;
      exp_v = exp_v + G;
      run_window("bnd_a", exp_v, v);
      check("bnd_a_literal", bus6.FREQ_BCD, 24'h000003);
      exp_v = exp_v + G;
      run_window("bnd_b", exp_v, v);
      check("bnd_b_literal", bus6.FREQ_BCD, 24'h000001);

      // CE dropped mid-window: no result, previous value holds, restart measures a full window
      mode = 1;
      repeat (500) @(negedge clk);
      ce    = 1'b0;
      held6 = bus6.FREQ_BCD;
      quiet = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus6.VALID !== 1'b0 || bus6.FREQ_BCD !== held6) quiet++;
      end
      check_int("ce_drop_quiet", quiet, 0);
      check("ce_drop_hold", bus6.FREQ_BCD, 24'h000001);
      check_int("ce_drop_state", int'(st6), int'(IDLE));
      ce = 1'b1;
      @(negedge clk);
      exp_v = e0 + G - 1;
      run_window("ce_w1", exp_v, v);
      exp_v = exp_v + G;
      run_window("ce_w2", exp_v, v);
      check("ce_w2_literal", bus6.FREQ_BCD, 24'h000100);

      // reset mid-window
      repeat (300) @(negedge clk);
      rst  = 1'b1;
      ce   = 1'b0;
      mode = 0;
      @(negedge clk);
      check("midrst_freq6", bus6.FREQ_BCD, 24'h0);
      check("midrst_valid6", 24'(bus6.VALID), 24'h0);
      check("midrst_ovf6", 24'(bus6.OVF), 24'h0);
      check("midrst_ovf2", 24'(bus2.OVF), 24'h0);
      check_int("midrst_state6", int'(st6), int'(IDLE));

      // SIG_IN held high: every window reads zero
      sig = 1'b1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      exp_v = e0 + G - 1;
      run_window("hi_w1", exp_v, v);
      check("hi_w1_literal", bus6.FREQ_BCD, 24'h0);
      exp_v = exp_v + G;
      run_window("hi_w2", exp_v, v);
      check("hi_w2_literal", bus6.FREQ_BCD, 24'h0);
      check("hi_w2_ovf2", 24'(bus2.OVF), 24'h0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/freq_meter_bcd.md
# freq_meter_bcd

Measures the frequency of an external square wave (`SIG_IN`) by counting its rising edges over a fixed gate window of `GATE_CYCLES` system clocks. It presents the result as packed 8421 BCD digits with a valid strobe and an overflow flag. It is the measuring end of the clock-division chain: it checks divided outputs and external signals against the 50 MHz system clock and feeds the digit display.

## Interface
- `GATE_CYCLES`, 50_000_000, gate window length in `CP_50M` cycles (1 s at 50 MHz); must be ≥ 4.
- `DIGITS`, 6, number of BCD decades in the result (full scale 10^DIGITS − 1).
- `CP_50M` in 1: system clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `CE` in 1: measurement enable, high = run continuously.
- `SIG_IN` in 1: signal under measurement, asynchronous to `CP_50M`.
- `FREQ_BCD` out 4*DIGITS: last latched count, digit 0 (units) in bits [3:0].
- `VALID` out 1: one-cycle pulse when `FREQ_BCD`/`OVF` update.
- `OVF` out 1: last latched window exceeded full scale.

## Operation
- Input path: two-flop synchronizer on `SIG_IN`, then a third flop. `edge` = sync2 & ~sync3.
- BCD counter: `DIGITS` cascaded decades. Each decade counts 0–9, wraps to 0, and carries to the next decade when it is at 9 and incremented.
- Gate counter: 0..GATE_CYCLES−1, width $clog2(GATE_CYCLES).
- FSM states are `IDLE`, `COUNT` and `LATCH`.
  - `IDLE`: BCD counter and gate counter held at 0, internal overflow cleared. Goes to `COUNT` when `CE`=1.
  - `COUNT`: gate counter increments each cycle and `edge` increments the BCD counter. Goes to `LATCH` when the gate counter reaches GATE_CYCLES−2.
  - `LATCH`, one cycle:
    - `FREQ_BCD` ← BCD counter, `OVF` ← internal overflow, `VALID`=1.
    - BCD counter loads 1 if `edge` is high this cycle, else 0. Gate counter ← 0, internal overflow cleared.
    - Goes to `COUNT` if `CE`=1, else `IDLE`.
  - Each window is exactly GATE_CYCLES cycles (GATE_CYCLES−1 in `COUNT` + 1 in `LATCH`). Consecutive windows tile with no lost or double-counted edges.
- `CE` low in `COUNT`: go to `IDLE` the next cycle, partial count discarded, no `VALID`. `FREQ_BCD`/`OVF` hold their previous values.
- Overflow: a carry out of the top decade sets the internal overflow flag, which stays set until `LATCH` or `IDLE`. Behaviour of the digits at overflow is set by the macro in Configuration.
- Input limit: `SIG_IN` high and low phases each ≥ 2 `CP_50M` periods. Faster inputs are undercounted, with no error flag.

## Timing
- Reset values:
  - `FREQ_BCD`=0, `VALID`=0, `OVF`=0.
  - FSM `IDLE`, all counters 0, synchronizer flops 0.
- `RST` overrides all other inputs. Asserted mid-window, it returns everything to reset values on the next edge, with no `VALID`.
- Edge latency: a `SIG_IN` rise is counted 3 cycles after it is sampled. A rise in the last 3 cycles of a window is counted in the next window.
- Start-up: `CE` rises in cycle t, so `COUNT` begins at t+1 and the first `VALID` is at t+GATE_CYCLES. After that, `VALID` repeats every GATE_CYCLES cycles.
- `FREQ_BCD` and `OVF` change only in the cycle `VALID` is high, and are stable otherwise.

## Configuration
- Macro: `FREQ_METER_SAT_EN`.
- Defined: after an overflow the digits saturate at all-9s for the rest of the window, and the latched result is full scale with `OVF`=1.
- Undefined: the digits wrap modulo 10^DIGITS, and the latched result is the wrapped count with `OVF`=1.

## Structure
- Package `freq_meter_pkg` holds:
  - the FSM state enum (`IDLE`, `COUNT`, `LATCH`);
  - the 4-bit BCD digit typedef;
  - the constant `BCD_MAX` = 4'h9.
- Sub-module `bcd_decade`: one decade with inputs inc/clr/load1 and outputs digit and carry. It is instantiated `DIGITS` times in a generate loop, with the top decade's carry driving overflow.

## Test plan
- GATE_CYCLES=1000, DIGITS=6, `CE`=1, `SIG_IN` period 10 cycles → `VALID` at cycle 1000 after start, `FREQ_BCD`=24'h000100, `OVF`=0. Values repeat every 1000 cycles.
- Window boundary: place a `SIG_IN` rise so its edge detect lands in the `LATCH` cycle → that edge is in window N+1, and the sum over two windows equals the total number of rises.
- Overflow: DIGITS=2, GATE_CYCLES=1000, 150 rises per window.
  - With `FREQ_METER_SAT_EN`: `FREQ_BCD`=8'h99, `OVF`=1.
  - Without the macro: `FREQ_BCD`=8'h50, `OVF`=1.
  - A following window with 20 rises gives 8'h20, `OVF`=0.
- `CE` dropped at cycle 500 of a window → no `VALID`, `FREQ_BCD` keeps its prior value. `CE` reasserted → the next `VALID` comes exactly GATE_CYCLES cycles later with a full-window count.
- `RST` pulsed mid-window after a prior result of 24'h000100 → the next cycle has `FREQ_BCD`=0, `VALID`=0, `OVF`=0 and FSM `IDLE`.
- `SIG_IN` held constant at 1 → each window gives `VALID` with `FREQ_BCD`=0 and `OVF`=0.
